// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains bytes from an 8-bit synchronous FIFO read port.
// Frame format: 1 start bit, 8 data bits LSB first, no parity, STOP_BITS stop bits.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    state_t      state, state_n;
    logic [15:0] baud_cnt, baud_cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift, shift_n;
    logic        tx_q, tx_n;
    logic        bit_end;

    assign bit_end = (baud_cnt == BIT_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values of its peers regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            tx_q     <= tx_n;
        end
    end

    // NOTE: every output of this block gets a default before the case statement,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        fifo_rd_en = 1'b0;
        frame_done = 1'b0;

        unique case (state)
            IDLE: begin
                // Gated by rst so the FIFO is never popped while the block is held in reset.
                fifo_rd_en = en & ~fifo_empty & ~rst;
                baud_cnt_n = '0;
                bit_idx_n  = '0;
                if (fifo_rd_en) state_n = FETCH;
            end
            FETCH: begin
                shift_n    = fifo_data;
                baud_cnt_n = '0;
                state_n    = START;
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = DATA;
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    shift_n    = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = '0;
                        state_n   = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                // bit_idx is reused to count stop bits.
                if (bit_end) begin
                    baud_cnt_n = '0;
                    if (bit_idx == STOP_LAST) begin
                        frame_done = 1'b1;
                        bit_idx_n  = '0;
                        state_n    = IDLE;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // The line level is decided from the next state so the tx register tracks the FSM exactly.
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: instance 0 uses one stop bit, instance 1 two stop bits,
// both at 4 clocks per bit, each fed by a small registered-FIFO model.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en         [2];
    logic       fifo_empty [2];
    logic [7:0] fifo_data  [2];
    logic       fifo_rd_en [2];
    logic       tx         [2];
    logic       busy       [2];
    logic       frame_done [2];

    logic [7:0] mem    [2][32];
    int         wr_ptr [2];
    int         rd_ptr [2];
    int         rd_cnt [2];
    int         underflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .en(en[0]), .fifo_empty(fifo_empty[0]),
        .fifo_data(fifo_data[0]), .fifo_rd_en(fifo_rd_en[0]), .tx(tx[0]),
        .busy(busy[0]), .frame_done(frame_done[0])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .en(en[1]), .fifo_empty(fifo_empty[1]),
        .fifo_data(fifo_data[1]), .fifo_rd_en(fifo_rd_en[1]), .tx(tx[1]),
        .busy(busy[1]), .frame_done(frame_done[1])
    );

    assign fifo_empty[0] = (wr_ptr[0] == rd_ptr[0]);
    assign fifo_empty[1] = (wr_ptr[1] == rd_ptr[1]);

    // FIFO read side: data is registered, valid the cycle after an accepted read.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (fifo_rd_en[i]) begin
                if (fifo_empty[i]) underflow <= underflow + 1;
                else begin
                    fifo_data[i] <= mem[i][rd_ptr[i] % 32];
                    rd_ptr[i]    <= rd_ptr[i] + 1;
                end
                rd_cnt[i] <= rd_cnt[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        mem[i][wr_ptr[i] % 32] = b;
        wr_ptr[i] = wr_ptr[i] + 1;
    endtask

    // Returns at the negedge of the first start-bit cycle; gap counts tx-high cycles seen before it.
    task automatic wait_start(input int i, input int budget, input string tag, output int gap);
        gap = 0;
        while (tx[i] !== 1'b0 && gap < budget) begin
            gap++;
            @(negedge clk);
        end
        check(tag, 32'(tx[i]), 32'd0);
    endtask

    // Receiver model: samples every cycle of the frame, checks the waveform shape and
    // returns at the negedge of the first IDLE cycle after the last stop bit.
    task automatic recv_frame(input int i, input int stop_bits, input string tag,
                              output logic [7:0] b);
        int n;
        int bad;
        logic [7:0] d;
        logic exp_tx;
        n   = (9 + stop_bits) * CPB;
        bad = 0;
        d   = '0;
        for (int c = 0; c < n; c++) begin
            int bit_no;
            bit_no = c / CPB;
            if (bit_no >= 1 && bit_no <= 8 && (c % CPB) == 0) d[bit_no-1] = tx[i];
            if (bit_no == 0)      exp_tx = 1'b0;
            else if (bit_no <= 8) exp_tx = d[bit_no-1];
            else                  exp_tx = 1'b1;
            if (tx[i] !== exp_tx)               bad++;
            if (frame_done[i] !== (c == n - 1)) bad++;
            if (busy[i] !== 1'b1)               bad++;
            if (fifo_rd_en[i] !== 1'b0)         bad++;
            @(negedge clk);
        end
        if (busy[i] !== 1'b0 || tx[i] !== 1'b1 || frame_done[i] !== 1'b0) bad++;
        check({tag, "_shape"}, 32'(bad), 32'd0);
        b = d;
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] stress [16];
        int gap;

        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; wr_ptr[i] = 0; rd_ptr[i] = 0; rd_cnt[i] = 0; fifo_data[i] = '0;
        end
        underflow = 0;
        rst = 1'b1;

        // Reset state; instance 1 already has data and en=1 but must not read under reset.
        push(1, 8'h81);
        en[1] = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx0", 32'(tx[0]), 32'd1);
        check("rst_busy0", 32'(busy[0]), 32'd0);
        check("rst_done0", 32'(frame_done[0]), 32'd0);
        check("rst_rd_en1", 32'(fifo_rd_en[1]), 32'd0);
        check("rst_tx1", 32'(tx[1]), 32'd1);
        rst = 1'b0;

        // Two stop bits, 0x81: 44-cycle frame.
        wait_start(1, 10, "stop2_start", gap);
        check("stop2_gap", 32'(gap), 32'd2);
        recv_frame(1, 2, "stop2", rx);
        check("stop2_byte", 32'(rx), 32'h81);
        check("stop2_rd_cnt", 32'(rd_cnt[1]), 32'd1);
        en[1] = 1'b0;
        check("idle_empty_busy0", 32'(busy[0]), 32'd0);
        check("idle_empty_rd_cnt0", 32'(rd_cnt[0]), 32'd0);

        // Single byte 0xA5.
        push(0, 8'hA5);
        en[0] = 1'b1;
        wait_start(0, 10, "a5_start", gap);
        recv_frame(0, 1, "a5", rx);
        check("a5_byte", 32'(rx), 32'hA5);
        check("a5_rd_cnt", 32'(rd_cnt[0]), 32'd1);
        repeat (10) @(negedge clk);
        check("a5_idle_busy", 32'(busy[0]), 32'd0);
        check("a5_idle_rd_cnt", 32'(rd_cnt[0]), 32'd1);

        // Back-to-back 0x00, 0xFF, 0x3C with a two-cycle idle gap between frames.
        push(0, 8'h00); push(0, 8'hFF); push(0, 8'h3C);
        wait_start(0, 10, "b2b0_start", gap);
        recv_frame(0, 1, "b2b0", rx);
        check("b2b0_byte", 32'(rx), 32'h00);
        wait_start(0, 10, "b2b1_start", gap);
        check("b2b1_gap", 32'(gap), 32'd2);
        recv_frame(0, 1, "b2b1", rx);
        check("b2b1_byte", 32'(rx), 32'hFF);
        wait_start(0, 10, "b2b2_start", gap);
        check("b2b2_gap", 32'(gap), 32'd2);
        recv_frame(0, 1, "b2b2", rx);
        check("b2b2_byte", 32'(rx), 32'h3C);
        check("b2b_rd_cnt", 32'(rd_cnt[0]), 32'd4);
        check("b2b_empty", 32'(fifo_empty[0]), 32'd1);

        // Reset asserted mid-DATA while tx is low (bit 0 of 0xF0).
        push(0, 8'hF0);
        wait_start(0, 10, "mid_start", gap);
        repeat (6) @(negedge clk);
        check("mid_tx_before", 32'(tx[0]), 32'd0);
        check("mid_busy_before", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_tx_async", 32'(tx[0]), 32'd1);
        check("mid_busy_async", 32'(busy[0]), 32'd0);
        check("mid_rd_en", 32'(fifo_rd_en[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_after_busy", 32'(busy[0]), 32'd0);
        check("mid_after_tx", 32'(tx[0]), 32'd1);
        check("mid_after_rd_cnt", 32'(rd_cnt[0]), 32'd5);

        // en gating: nothing happens with en=0, and dropping en mid-frame allows no second read.
        en[0] = 1'b0;
        push(0, 8'h55); push(0, 8'h66);
        repeat (50) @(negedge clk);
        check("engate_rd_cnt", 32'(rd_cnt[0]), 32'd5);
        check("engate_tx", 32'(tx[0]), 32'd1);
        en[0] = 1'b1;
        wait_start(0, 10, "engate_start", gap);
        fork
            begin
                repeat (2) @(negedge clk);
                en[0] = 1'b0;
            end
        join_none
        recv_frame(0, 1, "engate", rx);
        check("engate_byte", 32'(rx), 32'h55);
        repeat (20) @(negedge clk);
        check("engate_no_second_read", 32'(rd_cnt[0]), 32'd6);
        check("engate_idle_busy", 32'(busy[0]), 32'd0);

        // Stress: 0x66 still queued, then 16 random bytes pushed at random intervals.
        for (int k = 0; k < 16; k++) stress[k] = 8'($urandom_range(0, 255));
        en[0] = 1'b1;
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    repeat ($urandom_range(5, 60)) @(negedge clk);
                    push(0, stress[k]);
                end
            end
        join_none
        wait_start(0, 100, "stress_first_start", gap);
        recv_frame(0, 1, "stress_first", rx);
        check("stress_first_byte", 32'(rx), 32'h66);
        for (int k = 0; k < 16; k++) begin
            wait_start(0, 2000, $sformatf("stress%0d_start", k), gap);
            recv_frame(0, 1, $sformatf("stress%0d", k), rx);
            check($sformatf("stress%0d_byte", k), 32'(rx), 32'(stress[k]));
        end
        check("stress_rd_cnt", 32'(rd_cnt[0]), 32'd23);
        check("stress_empty", 32'(fifo_empty[0]), 32'd1);
        check("underflow", 32'(underflow), 32'd0);
        check("inst1_rd_cnt", 32'(rd_cnt[1]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
